// File: rtl/tdm_pkg.sv
// Shared types and constants for the tdm_demux4 four-lane TDM demultiplexer.
package tdm_pkg;
  localparam int NUM_LANES = 4;
  localparam int SLOT_W    = 2;

  typedef enum logic {HUNT, LOCK} tdm_state_t;

  typedef logic [SLOT_W-1:0] slot_t;
endpackage

// File: rtl/tdm_demux4_if.sv
// Serial word input and per-lane output bundle for tdm_demux4.
interface tdm_demux4_if #(parameter int DATA_W = 8);
  import tdm_pkg::*;

  logic                        in_valid;
  logic                        in_sof;
  logic [DATA_W-1:0]           in_data;
  logic [NUM_LANES*DATA_W-1:0] out_data;
  logic [NUM_LANES-1:0]        out_valid;
  logic                        frame_done;
  logic                        locked;
  logic                        sync_err;

  modport master (
    output in_valid, in_sof, in_data,
    input  out_data, out_valid, frame_done, locked, sync_err
  );

  modport slave (
    input  in_valid, in_sof, in_data,
    output out_data, out_valid, frame_done, locked, sync_err
  );
endinterface

// File: rtl/tdm_sync_fsm.sv
// HUNT/LOCK frame synchroniser with slot counter; emits combinational capture,
// frame-complete and sync-error strobes for the current input word.
module tdm_sync_fsm
  import tdm_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  in_valid,
  input  logic  in_sof,
  output logic  cap,
  output slot_t cap_slot,
  output logic  frame_done,
  output logic  sync_err,
  output logic  locked
);
  tdm_state_t state_q, state_d;
  slot_t      slot_q, slot_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HUNT;
      slot_q  <= '0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    slot_d     = slot_q;
    cap        = 1'b0;
    cap_slot   = slot_q;
    frame_done = 1'b0;
    sync_err   = 1'b0;
    if (in_valid) begin
      unique case (state_q)
        HUNT: begin
          if (in_sof) begin
            cap      = 1'b1;
            cap_slot = '0;
            slot_d   = slot_t'(1);
            state_d  = LOCK;
          end
        end
        LOCK: begin
          if (slot_q == '0) begin
            if (in_sof) begin
              cap      = 1'b1;
              cap_slot = '0;
              slot_d   = slot_t'(1);
            end else begin
              sync_err = 1'b1;
              slot_d   = '0;
              state_d  = HUNT;
            end
          end else if (in_sof) begin
            // Early sof restarts the frame in place rather than rehunting.
            sync_err = 1'b1;
            cap      = 1'b1;
            cap_slot = '0;
            slot_d   = slot_t'(1);
          end else begin
            cap        = 1'b1;
            slot_d     = slot_q + slot_t'(1);
            frame_done = (slot_q == slot_t'(NUM_LANES - 1));
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  assign locked = (state_q == LOCK);
endmodule

// File: rtl/tdm_demux4.sv
// Four-lane TDM demultiplexer: lane registers plus optional frame-aligned
// shadow buffer (enabled by defining TDM_DEMUX_FRAME_ALIGN_EN).
module tdm_demux4 #(
  parameter int DATA_W    = 8,
  parameter int NUM_LANES = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  tdm_demux4_if.slave   bus
);
  import tdm_pkg::*;

  logic  cap, done, err;
  slot_t cap_slot;

  logic [NUM_LANES-1:0][DATA_W-1:0] lane_q;
  logic [NUM_LANES-1:0]             valid_q;
  logic                             done_q, err_q;

  tdm_sync_fsm u_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (bus.in_valid),
    .in_sof     (bus.in_sof),
    .cap        (cap),
    .cap_slot   (cap_slot),
    .frame_done (done),
    .sync_err   (err),
    .locked     (bus.locked)
  );

`ifdef TDM_DEMUX_FRAME_ALIGN_EN
  logic [NUM_LANES-1:0][DATA_W-1:0] shadow_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= '0;
      lane_q   <= '0;
      valid_q  <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      valid_q <= '0;
      done_q  <= done;
      err_q   <= err;
      // Abandon clears the shadow first; an early-sof capture then refills lane 0.
      if (err)
        shadow_q <= '0;
      if (cap) begin
        if (done) begin
          lane_q   <= {bus.in_data, shadow_q[NUM_LANES-2:0]};
          valid_q  <= '1;
          shadow_q <= '0;
        end else begin
          shadow_q[cap_slot] <= bus.in_data;
        end
      end
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_q  <= '0;
      valid_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= '0;
      done_q  <= done;
      err_q   <= err;
      if (cap) begin
        lane_q[cap_slot] <= bus.in_data;
        valid_q          <= NUM_LANES'(1) << cap_slot;
      end
    end
  end
`endif

  assign bus.out_data   = lane_q;
  assign bus.out_valid  = valid_q;
  assign bus.frame_done = done_q;
  assign bus.sync_err   = err_q;
endmodule

// File: tb/tb_tdm_demux4.sv
// Directed self-checking bench for tdm_demux4 (default and frame-aligned builds).
module tb_tdm_demux4;
  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;
  int   step_no;

  tdm_demux4_if #(.DATA_W(8)) bus ();

  tdm_demux4 #(.DATA_W(8), .NUM_LANES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One input cycle, then check the registered outputs just after the edge.
  task automatic step(input logic v, input logic sof, input logic [7:0] d,
                      input logic [3:0] ev, input logic ed, input logic ee, input logic el);
    logic [3:0] exp_valid;
    @(negedge clk);
    bus.in_valid = v;
    bus.in_sof   = sof;
    bus.in_data  = d;
    @(posedge clk);
    #1;
    step_no++;
`ifdef TDM_DEMUX_FRAME_ALIGN_EN
    exp_valid = ed ? 4'b1111 : 4'b0000;
`else
    exp_valid = ev;
`endif
    check($sformatf("s%0d_valid", step_no), 64'(bus.out_valid), 64'(exp_valid));
    check($sformatf("s%0d_done", step_no), 64'(bus.frame_done), 64'(ed));
    check($sformatf("s%0d_err", step_no), 64'(bus.sync_err), 64'(ee));
    check($sformatf("s%0d_locked", step_no), 64'(bus.locked), 64'(el));
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
  endtask

  task automatic check_data(input string tag, input logic [31:0] exp);
    check(tag, 64'(bus.out_data), 64'(exp));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_data"},   64'(bus.out_data),   64'h0);
    check({tag, "_valid"},  64'(bus.out_valid),  64'h0);
    check({tag, "_done"},   64'(bus.frame_done), 64'h0);
    check({tag, "_locked"}, 64'(bus.locked),     64'h0);
    check({tag, "_err"},    64'(bus.sync_err),   64'h0);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    step_no = 0;
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
    bus.in_data  = '0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Clean frame
    step(1, 1, 8'h11, 4'b0001, 0, 0, 1);
    step(1, 0, 8'h22, 4'b0010, 0, 0, 1);
    step(1, 0, 8'h33, 4'b0100, 0, 0, 1);
    step(1, 0, 8'h44, 4'b1000, 1, 0, 1);
    check_data("clean_data", 32'h44332211);
    step(0, 0, 8'hEE, 4'b0000, 0, 0, 1);

    // Missing sof at slot 0: drop, error, unlock
    step(1, 0, 8'h55, 4'b0000, 0, 1, 0);
    check_data("miss_data", 32'h44332211);

    // Hunt drops non-sof words
    step(1, 0, 8'hAA, 4'b0000, 0, 0, 0);
    step(1, 0, 8'hBB, 4'b0000, 0, 0, 0);
    check_data("hunt_data", 32'h44332211);
    step(1, 1, 8'hA1, 4'b0001, 0, 0, 1);
    step(1, 0, 8'hA2, 4'b0010, 0, 0, 1);
    step(1, 0, 8'hA3, 4'b0100, 0, 0, 1);
    step(1, 0, 8'hA4, 4'b1000, 1, 0, 1);
    check_data("relock_data", 32'hA4A3A2A1);

    // Early sof abandons the partial frame
    step(1, 1, 8'h01, 4'b0001, 0, 0, 1);
    step(1, 0, 8'h02, 4'b0010, 0, 0, 1);
    step(1, 1, 8'h10, 4'b0001, 0, 1, 1);
`ifdef TDM_DEMUX_FRAME_ALIGN_EN
    check_data("early_hold", 32'hA4A3A2A1);
`else
    check_data("early_lane0", 32'hA4A30210);
`endif
    step(1, 0, 8'h20, 4'b0010, 0, 0, 1);
    step(1, 0, 8'h30, 4'b0100, 0, 0, 1);
    step(1, 0, 8'h40, 4'b1000, 1, 0, 1);
    check_data("early_data", 32'h40302010);

    // Idle gaps inside a frame
    step(1, 1, 8'h11, 4'b0001, 0, 0, 1);
    step(1, 0, 8'h22, 4'b0010, 0, 0, 1);
    step(0, 1, 8'h99, 4'b0000, 0, 0, 1);
    step(0, 0, 8'h98, 4'b0000, 0, 0, 1);
    step(0, 1, 8'h97, 4'b0000, 0, 0, 1);
    step(1, 0, 8'h33, 4'b0100, 0, 0, 1);
    step(1, 0, 8'h44, 4'b1000, 1, 0, 1);
    check_data("gap_data", 32'h44332211);

    // Reset mid-frame clears everything at once
    step(1, 1, 8'h66, 4'b0001, 0, 0, 1);
    step(1, 0, 8'h77, 4'b0010, 0, 0, 1);
    step(1, 0, 8'h88, 4'b0100, 0, 0, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 0, 8'h99, 4'b0000, 0, 0, 0);
    step(1, 1, 8'hC1, 4'b0001, 0, 0, 1);
    step(1, 0, 8'hC2, 4'b0010, 0, 0, 1);
    step(1, 0, 8'hC3, 4'b0100, 0, 0, 1);
    step(1, 0, 8'hC4, 4'b1000, 1, 0, 1);
    check_data("postrst_data", 32'hC4C3C2C1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/tdm_demux4.md
Name: tdm_demux4

Overview:
- Four-lane time-division demultiplexer; receive-side counterpart of the 4:1 lane mux.
- Accepts a serial word stream in which each frame is four consecutive valid words, slot 0 first, with slot 0 flagged by in_sof.
- Routes slot k to output lane k and maintains frame lock, flagging sync errors.
- Sits between the serial link capture logic and the per-lane consumers.

Parameters:
- DATA_W, 8, width of one lane word.
- NUM_LANES, 4, lanes per frame; fixed at 4; the slot counter is 2 bits.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  in_data/in_sof valid this cycle; no backpressure.
- in_sof  input  1  marks the slot-0 word of a frame; ignored when in_valid=0.
- in_data  input  DATA_W  incoming lane word.
- out_data  output  4*DATA_W  lane k occupies bits [k*DATA_W +: DATA_W].
- out_valid  output  4  bit k pulses for one cycle when lane k is updated.
- frame_done  output  1  one-cycle pulse when a complete frame (slots 0..3) has been delivered.
- locked  output  1  high while the FSM is in LOCK.
- sync_err  output  1  one-cycle pulse on a framing violation.

Behaviour:
- Reset (async assert, synchronous-release use): FSM=HUNT, slot=0, out_data=0, out_valid=0, frame_done=0, locked=0, sync_err=0.
- Reset asserted mid-frame discards the partial frame. Nothing is delivered for it.
- An accepted word is one with in_valid=1. Idle cycles (in_valid=0) change no state and are legal anywhere in a frame.
- FSM state HUNT:
  - in_sof=0 words are dropped silently.
  - A word with in_sof=1 is slot 0: lane 0 is captured, slot becomes 1, and the FSM enters LOCK.
- FSM state LOCK, with expected slot s:
  - s=1..3 and in_sof=0: capture to lane s, then s=s+1 (wraps 3 to 0).
  - s=0 and in_sof=1: capture to lane 0, s=1.
  - s=1..3 and in_sof=1 (early sof): sync_err pulses. The word is treated as a new slot 0: lane 0 is captured, s=1, the FSM stays in LOCK, and the partial frame is abandoned (no frame_done).
  - s=0 and in_sof=0 (missing sof): sync_err pulses, the word is dropped, the FSM goes to HUNT and slot is reset to 0.
- Latency: a word accepted at edge n appears on out_data, with its out_valid bit, after edge n+1 (one register stage).
- out_valid is never asserted for more than one bit per cycle.
- frame_done pulses in the same cycle as out_valid[3], and only if slots 0..3 were all accepted in order without an intervening error.
- sync_err and the corresponding capture (early-sof case) appear in the same output cycle.
- out_data lanes hold their last value until overwritten. Dropped words never modify out_data.
- locked: 1 from the cycle after the LOCK entry edge; 0 from the cycle after the drop to HUNT.

Optional Feature:
- Macro: TDM_DEMUX_FRAME_ALIGN_EN.
- Defined: captured words go into a 4-lane shadow buffer. out_data is updated for all four lanes at once, one cycle after slot 3 is accepted. out_valid pulses 4'b1111 coincident with frame_done. Abandoned frames never reach out_data; the shadow buffer is cleared on abandon and on reset.
- Undefined: per-lane update as described above, and no shadow buffer is instantiated.

Decomposition:
- Package tdm_pkg:
  - NUM_LANES=4 and SLOT_W=2;
  - enum tdm_state_t {HUNT, LOCK};
  - slot_t typedef (logic [SLOT_W-1:0]).
- One sub-module, tdm_sync_fsm: HUNT/LOCK FSM plus slot counter. It outputs capture strobe, slot index, frame_done, sync_err and locked.
- The top level holds the lane registers and the optional shadow buffer.

Test Plan:
- Clean frame: reset, then words (sof=1,0x11),(0,0x22),(0,0x33),(0,0x44) on back-to-back cycles -> out_valid 0001,0010,0100,1000 on successive cycles; out_data=0x44332211; frame_done with lane 3; locked=1; sync_err never.
- Hunt drop: words (0,0xAA),(0,0xBB) then a clean frame -> the first two words are dropped and out_data is unchanged by them; locked rises only after the sof word.
- Early sof: after (1,0x01),(0,0x02), send (1,0x10),(0,0x20),(0,0x30),(0,0x40) -> sync_err once, at the 0x10 capture; no frame_done for the partial frame; one frame_done later; out_data=0x40302010.
- Missing sof: after a full frame, send (0,0x55) -> sync_err; locked falls; 0x55 is not captured; the next sof frame relocks.
- Idle gaps and reset: frame with 3 idle cycles between slots 1 and 2 -> same result as the clean frame. Separately, assert rst_n low after slot 2 -> all outputs 0 immediately; the next full frame delivers normally.
- With TDM_DEMUX_FRAME_ALIGN_EN: clean frame -> a single out_valid=1111 together with frame_done. The early-sof scenario -> out_data is unchanged until the good frame completes.
